// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the single-cycle
// ALU/MEM writeback path and the long-latency unit. The ALU wins by default. A
// starvation counter forces one LU grant after STARVE_MAX consecutive LU denials.
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_rd,
    input  logic [DATA_W-1:0] lu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_sel,
    output logic              starved
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ALU_PRI  = 1'b0,
        LU_FORCE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              alu_rdy_c, lu_rdy_c;
    logic              alu_xfer_c, lu_xfer_c;
    logic              rf_we_d, wb_sel_d, starved_d;
    logic [ADDR_W-1:0] rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_d;

    // State, counter and registered write-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ALU_PRI;
            cnt_q    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_sel   <= 1'b0;
            starved  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rf_we    <= rf_we_d;
            rf_waddr <= rf_waddr_d;
            rf_wdata <= rf_wdata_d;
            wb_sel   <= wb_sel_d;
            starved  <= starved_d;
        end
    end

    // Arbitration: next state, starvation count and per-producer readies
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_rdy_c = 1'b0;
        lu_rdy_c  = 1'b0;
        unique case (state_q)
            ALU_PRI: begin
                if (alu_valid) begin
                    alu_rdy_c = 1'b1;
                    if (lu_valid) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(STARVE_MAX - 1)) begin
                            state_d = LU_FORCE;
                        end
                    end
                end else if (lu_valid) begin
                    lu_rdy_c = 1'b1;
                    cnt_d    = '0;
                end
            end
            LU_FORCE: begin
                // ALU stalls for one cycle; LU gets the port whether or not it asks
                lu_rdy_c = 1'b1;
                state_d  = ALU_PRI;
                cnt_d    = '0;
            end
            default: begin
                state_d = ALU_PRI;
                cnt_d   = '0;
            end
        endcase
    end

    // Readies are held low during reset; requests in flight are dropped
    assign alu_ready  = alu_rdy_c & ~reset;
    assign lu_ready   = lu_rdy_c & ~reset;
    assign alu_xfer_c = alu_valid & alu_ready;
    assign lu_xfer_c  = lu_valid & lu_ready;

    // Winning write for next cycle; writes to r0 are accepted but dropped
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
        wb_sel_d   = wb_sel;
        starved_d  = (state_d == LU_FORCE);
        if (alu_xfer_c && (alu_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_data;
            wb_sel_d   = 1'b0;
        end else if (lu_xfer_c && (lu_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = lu_rd;
            rf_wdata_d = lu_data;
            wb_sel_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (DATA_W=32, ADDR_W=5, STARVE_MAX=4).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, lu_valid;
    logic        alu_ready, lu_ready;
    logic [4:0]  alu_rd, lu_rd;
    logic [31:0] alu_data, lu_data;
    logic        rf_we, wb_sel, starved;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_rd     (lu_rd),
        .lu_data   (lu_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .wb_sel    (wb_sel),
        .starved   (starved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic a, input logic l, input logic s);
        chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(a));
        chk({tag, ".lu_ready"},  32'(lu_ready),  32'(l));
        chk({tag, ".starved"},   32'(starved),   32'(s));
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic sel);
        chk({tag, ".rf_we"},    32'(rf_we),    32'(we));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(a));
        chk({tag, ".rf_wdata"}, rf_wdata,      d);
        chk({tag, ".wb_sel"},   32'(wb_sel),   32'(sel));
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b1; lu_valid = 1'b1;
        alu_rd = 5'd1; alu_data = 32'h1; lu_rd = 5'd2; lu_data = 32'h2;
        tick(); tick();
        // Reset state: readies held low even with both producers requesting
        chk_ready("rst", 1'b0, 1'b0, 1'b0);
        chk_wr("rst", 1'b0, 5'd0, 32'h0, 1'b0);

        reset = 1'b0; alu_valid = 1'b0; lu_valid = 1'b0;
        tick();

        // ALU write alone
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
        chk_ready("alu", 1'b1, 1'b0, 1'b0);
        tick();
        chk_wr("alu", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);

        // LU write alone
        alu_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h12345678; #1;
        chk_ready("lu", 1'b0, 1'b1, 1'b0);
        tick();
        chk_wr("lu", 1'b1, 5'd7, 32'h12345678, 1'b1);

        // Idle cycle: write enable drops, other outputs hold
        lu_valid = 1'b0; #1;
        chk_ready("idle", 1'b0, 1'b0, 1'b0);
        tick();
        chk_wr("idle", 1'b0, 5'd7, 32'h12345678, 1'b1);

        // Write to r0: accepted, no write, previous address/data held
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF; #1;
        chk_ready("r0", 1'b1, 1'b0, 1'b0);
        tick();
        chk_wr("r0", 1'b0, 5'd7, 32'h12345678, 1'b1);

        // Both valid continuously: ALU x4, LU x1, repeating
        alu_rd = 5'd3; alu_data = 32'hA0A0A0A0;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hB1B1B1B1; #1;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) begin
                chk_ready($sformatf("starve%0d", k), 1'b0, 1'b1, 1'b1);
                tick();
                chk_wr($sformatf("starve%0d", k), 1'b1, 5'd9, 32'hB1B1B1B1, 1'b1);
            end else begin
                chk_ready($sformatf("starve%0d", k), 1'b1, 1'b0, 1'b0);
                tick();
                chk_wr($sformatf("starve%0d", k), 1'b1, 5'd3, 32'hA0A0A0A0, 1'b0);
            end
        end

        // Forced-LU slot with LU idle: ALU still stalls, nothing written
        for (int k = 0; k < 4; k++) tick();
        lu_valid = 1'b0; #1;
        chk("fidle.alu_ready", 32'(alu_ready), 32'(1'b0));
        chk("fidle.starved",   32'(starved),   32'(1'b1));
        tick();
        chk("fidle.rf_we",     32'(rf_we),     32'(1'b0));
        chk_ready("fidle.after", 1'b1, 1'b0, 1'b0);

        // Async reset while in LU_FORCE: clears immediately, no clock edge
        lu_valid = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk_ready("pre_rst", 1'b0, 1'b1, 1'b1);
        #2 reset = 1'b1; #1;
        chk_ready("async_rst", 1'b0, 1'b0, 1'b0);
        chk_wr("async_rst", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        reset = 1'b0; #1;
        // Counter restarted: four ALU grants before the forced LU grant
        for (int k = 0; k < 5; k++) begin
            if (k == 4) chk_ready($sformatf("post_rst%0d", k), 1'b0, 1'b1, 1'b1);
            else        chk_ready($sformatf("post_rst%0d", k), 1'b1, 1'b0, 1'b0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
